// File: rtl/iob_native_arb.sv
// Round-robin arbiter sharing one native valid/ready master port among N_MASTERS requesters.
// Optional BUSY watchdog enabled by defining IOB_ARB_TIMEOUT_EN.
module iob_native_arb #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            s_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     s_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     s_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   s_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]     s_rdata,
    output logic [N_MASTERS-1:0]            s_ready,
    output logic                            m_valid,
    output logic [ADDR_W-1:0]               m_addr,
    output logic [DATA_W-1:0]               m_wdata,
    output logic [DATA_W/8-1:0]             m_wstrb,
    input  logic [DATA_W-1:0]               m_rdata,
    input  logic                            m_ready,
    output logic [N_MASTERS-1:0]            grant,
    output logic                            timeout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(N_MASTERS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             timeout_hit;
    logic             finish;
    logic             complete;

    // Search starts one past the last owner, so a continuous requester yields to any waiter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        winner  = last;
        any_req = 1'b0;
        for (int off = 1; off <= N_MASTERS; off++) begin
            logic [IDX_W:0]   sum;
            logic [IDX_W-1:0] idx;
            sum = {1'b0, last} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N_MASTERS))
                sum = sum - (IDX_W+1)'(N_MASTERS);
            idx = sum[IDX_W-1:0];
            if (!any_req && s_valid[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

`ifdef IOB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign timeout_hit = (state == BUSY) && !m_ready && (tmo_cnt == 16'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (!m_ready && !timeout_hit)
            tmo_cnt <= tmo_cnt + 16'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign finish   = m_ready || timeout_hit;
    // Gated by rst so an aborted transaction never reports completion.
    assign complete = (state == BUSY) && finish && !rst;
    assign timeout  = timeout_hit && !rst;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            owner   <= '0;
            last    <= IDX_W'(N_MASTERS - 1);
            m_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant   <= N_MASTERS'(1) << winner;
                        owner   <= winner;
                        m_valid <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        last    <= owner;
                        grant   <= '0;
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant is one-hot or zero, so an AND-OR mux yields zero fields while idle.
    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant[i]) begin
                m_addr  = m_addr  | s_addr [i*ADDR_W +: ADDR_W];
                m_wdata = m_wdata | s_wdata[i*DATA_W +: DATA_W];
                m_wstrb = m_wstrb | s_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        s_ready = '0;
        s_rdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (complete && grant[i]) begin
                s_ready[i]                  = 1'b1;
                s_rdata[i*DATA_W +: DATA_W] = m_ready ? m_rdata : {DATA_W{1'b1}};
            end
        end
    end

endmodule
